inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameter bw, default 8, operand bit width.
REQ-002 SHALL have parameter pr, default 8, operands per memory word.
REQ-003 SHALL have parameter col, default 8, array columns, passed through for consistency with the core.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1, command offered.
REQ-007 SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_op, input, 2, opcode: 0 LOAD_Q, 1 LOAD_K, 2 EXEC, 3 PSUM_RD.
REQ-009 SHALL have port cmd_addr, input, 4, start address.
REQ-010 SHALL have port cmd_len, input, 4, beat count minus one.
REQ-011 SHALL have port data_valid, input, 1, write-data beat offered.
REQ-012 SHALL have port data_ready, output, 1, beat consumed when high with data_valid.
REQ-013 SHALL have port data_in, input, pr*bw, write-data beat.
REQ-014 SHALL have port inst, output, 17, core instruction word.
REQ-015 SHALL have port mem_in, output, pr*bw, core data word.
REQ-016 SHALL have port busy, output, 1, high when not IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse when a command completes.

Function
REQ-018 inst fields SHALL be: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
REQ-019 All outputs SHALL be registered, and inst SHALL be all-zero in every cycle with no issued beat.
REQ-020 The FSM SHALL have states IDLE, WRITE, LOAD, GAP, EXEC, FLUSH, READ.
REQ-021 cmd_ready SHALL be high only in IDLE; on acceptance the FSM SHALL latch op/addr/len, clear beat index i, and enter WRITE (op 0/1), LOAD (op 2) or READ (op 3).
REQ-022 In WRITE, data_ready SHALL be high; each handshake SHALL issue next cycle mem_in=data_in, qkmem_add=addr+i mod 16, and qmem_wr (LOAD_Q) or kmem_wr (LOAD_K).
REQ-023 In WRITE, no beat SHALL issue when data_valid is low (stall, inst=0, i held).
REQ-024 In LOAD, the block SHALL issue kmem_rd+load at qkmem_add=addr+i for len+1 consecutive cycles, then spend one GAP cycle with inst=0.
REQ-025 In EXEC, the block SHALL issue qmem_rd+execute at qkmem_add=addr+i for len+1 cycles, each with pmem_wr and pmem_add=i-1 one cycle later; FLUSH SHALL issue the final pmem_wr only.
REQ-026 In READ, the block SHALL issue pmem_rd+ofifo_rd at pmem_add=addr+i for len+1 cycles.
REQ-027 Address arithmetic SHALL be 4-bit, wrapping 15→0.
REQ-028 done SHALL pulse in the cycle after the last beat issues, with the FSM returning to IDLE in the same cycle.
REQ-029 cmd_len=0 SHALL produce exactly one beat (EXEC: one execute, one pmem_wr).
REQ-030 data_ready SHALL be low outside WRITE, and beats offered outside WRITE SHALL be ignored.

Reset
REQ-031 On reset low, the FSM SHALL go to IDLE and inst, mem_in, i, busy, done, data_ready SHALL clear to 0 immediately, aborting any command in flight.
REQ-032 cmd_ready SHALL assert in the first clock edge after reset release.

Configuration
REQ-033 With INST_SEQ_PERF_EN defined, an output stall_cnt[15:0] SHALL count WRITE-state cycles with data_valid low, saturating at 0xFFFF, cleared by reset.
REQ-034 Without INST_SEQ_PERF_EN, the stall_cnt port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-035 Package inst_seq_pkg SHALL hold the opcode enum, the state enum and the inst bit-position constants.
REQ-036 A single sub-module seq_addr_ctr (beat index, address wrap, last-beat flag) SHALL be used.

Verification
REQ-037 LOAD_Q addr=2 len=3, data always valid → four qmem_wr beats at qkmem_add 2,3,4,5, mem_in matching, then done.
REQ-038 LOAD_K addr=14 len=3, data_valid low on second beat for 2 cycles → qkmem_add 14,15,0,1; 2 zero inst cycles; stall_cnt=2 when INST_SEQ_PERF_EN.
REQ-039 EXEC addr=0 len=7 → 8 load cycles, 1 zero cycle, 8 execute cycles, pmem_wr at pmem_add 0..7 each lagging one cycle, done.
REQ-040 PSUM_RD addr=4 len=0 → single pmem_rd+ofifo_rd at pmem_add 4, done the next cycle.
REQ-041 Reset asserted mid-EXEC → inst=0 and busy=0 immediately; after release cmd_ready=1 and a new LOAD_Q runs correctly.

Source files
------------

// File: rtl/inst_seq_pkg.sv
// Shared types and instruction-word layout for inst_sequencer and its beat counter.
package inst_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_Q  = 2'd0,
    OP_LOAD_K  = 2'd1,
    OP_EXEC    = 2'd2,
    OP_PSUM_RD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_LOAD,
    S_GAP,
    S_EXEC,
    S_FLUSH,
    S_READ
  } state_e;

  localparam int unsigned INST_W     = 17;
  localparam int unsigned B_OFIFO_RD = 16;
  localparam int unsigned QKMEM_LSB  = 12;
  localparam int unsigned PMEM_LSB   = 8;
  localparam int unsigned B_EXECUTE  = 7;
  localparam int unsigned B_LOAD     = 6;
  localparam int unsigned B_QMEM_RD  = 5;
  localparam int unsigned B_QMEM_WR  = 4;
  localparam int unsigned B_KMEM_RD  = 3;
  localparam int unsigned B_KMEM_WR  = 2;
  localparam int unsigned B_PMEM_RD  = 1;
  localparam int unsigned B_PMEM_WR  = 0;

endpackage

// File: rtl/seq_addr_ctr.sv
// Beat index for the sequencer: start address offset with 4-bit wrap and last-beat flag.
module seq_addr_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       step,
  input  logic [3:0] base,
  input  logic [3:0] len,
  output logic [3:0] idx,
  output logic [3:0] addr,
  output logic       last
);

  logic [3:0] idx_q;
  logic [3:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (step) begin
      idx_d = idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign addr = base + idx_q;
  assign last = (idx_q == len);

endmodule

// File: rtl/inst_sequencer.sv
// Command-driven instruction sequencer for the attention core; all outputs registered.
// Optional INST_SEQ_PERF_EN adds the stall_cnt write-stall counter output.
module inst_sequencer
  import inst_seq_pkg::*;
#(
  parameter int unsigned bw  = 8,
  parameter int unsigned pr  = 8,
  parameter int unsigned col = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_addr,
  input  logic [3:0]       cmd_len,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [pr*bw-1:0] data_in,
  output logic [16:0]      inst,
  output logic [pr*bw-1:0] mem_in,
  output logic             busy,
  output logic             done
`ifdef INST_SEQ_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int unsigned DW = pr * bw;

  if (bw < 1 || pr < 1 || col < 1) begin : g_param_check
    $error("inst_sequencer: bw, pr and col must all be at least 1");
  end

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [3:0]        addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic              fin_q, fin_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DW-1:0]     mem_in_q, mem_in_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              data_ready_q, data_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ctr_clr, ctr_step, ctr_last;
  logic [3:0]        ctr_idx, ctr_addr;

  seq_addr_ctr u_ctr (
    .clk  (clk),
    .reset(reset),
    .clr  (ctr_clr),
    .step (ctr_step),
    .base (addr_q),
    .len  (len_q),
    .idx  (ctr_idx),
    .addr (ctr_addr),
    .last (ctr_last)
  );

  // fin_q marks the cycle in which the final beat is on inst; the next edge returns to IDLE with done.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    len_d        = len_q;
    fin_d        = 1'b0;
    inst_d       = '0;
    mem_in_d     = mem_in_q;
    done_d       = 1'b0;
    data_ready_d = 1'b0;
    ctr_clr      = 1'b0;
    ctr_step     = 1'b0;

    if (fin_q) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_d    = op_e'(cmd_op);
            addr_d  = cmd_addr;
            len_d   = cmd_len;
            ctr_clr = 1'b1;
            case (op_e'(cmd_op))
              OP_LOAD_Q, OP_LOAD_K: begin
                state_d      = S_WRITE;
                data_ready_d = 1'b1;
              end
              OP_EXEC: state_d = S_LOAD;
              default: state_d = S_READ;
            endcase
          end
        end
        S_WRITE: begin
          if (data_valid && data_ready_q) begin
            inst_d[QKMEM_LSB +: 4] = ctr_addr;
            if (op_q == OP_LOAD_Q) begin
              inst_d[B_QMEM_WR] = 1'b1;
            end else begin
              inst_d[B_KMEM_WR] = 1'b1;
            end
            mem_in_d = data_in;
            if (ctr_last) begin
              fin_d = 1'b1;
            end else begin
              ctr_step     = 1'b1;
              data_ready_d = 1'b1;
            end
          end else begin
            data_ready_d = 1'b1;
          end
        end
        S_LOAD: begin
          inst_d[QKMEM_LSB +: 4] = ctr_addr;
          inst_d[B_KMEM_RD]      = 1'b1;
          inst_d[B_LOAD]         = 1'b1;
          if (ctr_last) begin
            state_d = S_GAP;
          end else begin
            ctr_step = 1'b1;
          end
        end
        S_GAP: begin
          ctr_clr = 1'b1;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          inst_d[QKMEM_LSB +: 4] = ctr_addr;
          inst_d[B_QMEM_RD]      = 1'b1;
          inst_d[B_EXECUTE]      = 1'b1;
          // Partial sum of the previous execute beat is written back alongside this one.
          if (ctr_idx != 4'd0) begin
            inst_d[PMEM_LSB +: 4] = ctr_idx - 4'd1;
            inst_d[B_PMEM_WR]     = 1'b1;
          end
          if (ctr_last) begin
            state_d = S_FLUSH;
          end else begin
            ctr_step = 1'b1;
          end
        end
        S_FLUSH: begin
          inst_d[PMEM_LSB +: 4] = len_q;
          inst_d[B_PMEM_WR]     = 1'b1;
          fin_d                 = 1'b1;
        end
        S_READ: begin
          inst_d[PMEM_LSB +: 4] = ctr_addr;
          inst_d[B_PMEM_RD]     = 1'b1;
          inst_d[B_OFIFO_RD]    = 1'b1;
          if (ctr_last) begin
            fin_d = 1'b1;
          end else begin
            ctr_step = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

`ifdef INST_SEQ_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_WRITE && data_ready_q && !data_valid && stall_q != '1) begin
      stall_d = stall_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_LOAD_Q;
      addr_q       <= '0;
      len_q        <= '0;
      fin_q        <= 1'b0;
      inst_q       <= '0;
      mem_in_q     <= '0;
      cmd_ready_q  <= 1'b0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef INST_SEQ_PERF_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      fin_q        <= fin_d;
      inst_q       <= inst_d;
      mem_in_q     <= mem_in_d;
      cmd_ready_q  <= cmd_ready_d;
      data_ready_q <= data_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef INST_SEQ_PERF_EN
      stall_q      <= stall_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign data_ready = data_ready_q;
  assign inst       = inst_q;
  assign mem_in     = mem_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef INST_SEQ_PERF_EN
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: command table with beat scoreboard plus cycle-exact sequences.
module tb_inst_sequencer;

  localparam int BW  = 8;
  localparam int PR  = 8;
  localparam int COL = 8;
  localparam int DW  = PR * BW;

  localparam logic [16:0] F_OFIFO = 17'h10000;
  localparam logic [16:0] F_EXEC  = 17'h00080;
  localparam logic [16:0] F_LOAD  = 17'h00040;
  localparam logic [16:0] F_QRD   = 17'h00020;
  localparam logic [16:0] F_QWR   = 17'h00010;
  localparam logic [16:0] F_KRD   = 17'h00008;
  localparam logic [16:0] F_KWR   = 17'h00004;
  localparam logic [16:0] F_PRD   = 17'h00002;
  localparam logic [16:0] F_PWR   = 17'h00001;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_addr;
  logic [3:0]    cmd_len;
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] data_in;
  logic [16:0]   inst;
  logic [DW-1:0] mem_in;
  logic          busy;
  logic          done;
`ifdef INST_SEQ_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  inst_sequencer #(.bw(BW), .pr(PR), .col(COL)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data_in   (data_in),
    .inst      (inst),
    .mem_in    (mem_in),
    .busy      (busy),
    .done      (done)
`ifdef INST_SEQ_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [3:0] len;
    int         stall_beat;
    int         stall_n;
    int         exp_beats;
    int         exp_stall;
  } vec_t;

  typedef struct {
    logic [16:0]   inst;
    logic          chk_mem;
    logic [DW-1:0] mem;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] wdata [16];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            mon_beats = 0;
  int            last_beat_cyc = 0;
  logic          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] qk(input logic [3:0] a);
    return {1'b0, a, 12'h000};
  endfunction

  function automatic logic [16:0] pa(input logic [3:0] a);
    return {5'b0, a, 8'h00};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor: every non-zero instruction word must match the next scoreboard entry.
  always @(negedge clk) begin
    if (mon_en && reset && inst !== '0) begin
      exp_t e;
      mon_beats++;
      last_beat_cyc = cyc;
      if (sbq.size() == 0) begin
        check("unexpected_beat", 64'(inst), 64'd0);
      end else begin
        e = sbq.pop_front();
        check("beat_inst", 64'(inst), 64'(e.inst));
        if (e.chk_mem) check("beat_mem", mem_in, e.mem);
      end
    end
  end

  task automatic push_expected(input vec_t v);
    int unsigned n;
    logic [3:0]  a;
    exp_t        e;
    n = 32'(v.len) + 1;
    e.chk_mem = 1'b0;
    e.mem     = '0;
    case (v.op)
      2'd0, 2'd1: begin
        for (int unsigned i = 0; i < n; i++) begin
          a         = v.addr + 4'(i);
          e.inst    = ((v.op == 2'd0) ? F_QWR : F_KWR) | qk(a);
          e.chk_mem = 1'b1;
          e.mem     = wdata[i];
          sbq.push_back(e);
        end
      end
      2'd2: begin
        for (int unsigned i = 0; i < n; i++) begin
          a      = v.addr + 4'(i);
          e.inst = F_KRD | F_LOAD | qk(a);
          sbq.push_back(e);
        end
        for (int unsigned i = 0; i < n; i++) begin
          a      = v.addr + 4'(i);
          e.inst = F_QRD | F_EXEC | qk(a);
          if (i > 0) e.inst = e.inst | F_PWR | pa(4'(i - 1));
          sbq.push_back(e);
        end
        e.inst = F_PWR | pa(v.len);
        sbq.push_back(e);
      end
      default: begin
        for (int unsigned i = 0; i < n; i++) begin
          a      = v.addr + 4'(i);
          e.inst = F_OFIFO | F_PRD | pa(a);
          sbq.push_back(e);
        end
      end
    endcase
  endtask

  // Offers a command and returns at the first falling edge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] l);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("cmd_ready_after_accept", 64'(cmd_ready), 64'd0);
  endtask

  task automatic run_cmd(input vec_t v);
    int          t;
    int          beats0;
    logic        is_wr;
    logic [15:0] st0;
    st0 = '0;
`ifdef INST_SEQ_PERF_EN
    st0 = stall_cnt;
`endif
    beats0 = mon_beats;
    is_wr  = (v.op == 2'd0 || v.op == 2'd1);
    for (int k = 0; k < 16; k++) wdata[k] = {$urandom, $urandom};
    push_expected(v);
    data_valid = !is_wr;
    data_in    = {$urandom, $urandom};
    issue(v.op, v.addr, v.len);
    if (is_wr) begin
      for (int k = 0; k <= int'(v.len); k++) begin
        if (k == v.stall_beat) begin
          for (int s = 0; s < v.stall_n; s++) begin
            data_valid = 1'b0;
            if (s > 0) check("stall_inst_zero", 64'(inst), 64'd0);
            @(negedge clk);
          end
          if (v.stall_n > 0) check("stall_inst_zero", 64'(inst), 64'd0);
        end
        data_valid = 1'b1;
        data_in    = wdata[k];
        t = 0;
        while (!data_ready && t < 20) begin
          @(negedge clk);
          t++;
        end
        @(negedge clk);
      end
      data_valid = 1'b0;
    end
    t = 0;
    while (!done && t < 100) begin
      if (!is_wr) check("data_ready_low", 64'(data_ready), 64'd0);
      @(negedge clk);
      t++;
    end
    data_valid = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("cmd_ready_at_done", 64'(cmd_ready), 64'd1);
    check("beat_count", 64'(mon_beats - beats0), 64'(v.exp_beats));
    check("done_lag", 64'(cyc - last_beat_cyc), 64'd1);
    check("sb_empty", 64'(sbq.size()), 64'd0);
`ifdef INST_SEQ_PERF_EN
    check("stall_cnt_delta", 64'(16'(stall_cnt - st0)), 64'(v.exp_stall));
`endif
    sbq.delete();
    @(negedge clk);
    check("done_pulse_once", 64'(done), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    logic [16:0] e;
    vecs[0] = '{2'd0, 4'd2,  4'd3,  -1, 0, 4,  0};
    vecs[1] = '{2'd1, 4'd14, 4'd3,  1,  2, 4,  2};
    vecs[2] = '{2'd2, 4'd0,  4'd0,  -1, 0, 3,  0};
    vecs[3] = '{2'd2, 4'd13, 4'd5,  -1, 0, 13, 0};
    vecs[4] = '{2'd3, 4'd15, 4'd2,  -1, 0, 3,  0};
    vecs[5] = '{2'd1, 4'd0,  4'd15, 15, 1, 16, 1};
    vecs[6] = '{2'd3, 4'd4,  4'd0,  -1, 0, 1,  0};

    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_addr   = '0;
    cmd_len    = '0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (3) @(negedge clk);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_mem_in", mem_in, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data_ready", 64'(data_ready), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
`ifdef INST_SEQ_PERF_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    mon_en = 1'b1;
    for (int v = 0; v < 7; v++) run_cmd(vecs[v]);

    // Cycle-exact EXEC addr=0 len=7: load, gap, execute with lagging pmem_wr, flush, done.
    mon_en = 1'b0;
    issue(2'd2, 4'd0, 4'd7);
    for (int n = 0; n < 19; n++) begin
      e = '0;
      if (n >= 1 && n <= 8) begin
        e = F_KRD | F_LOAD | qk(4'(n - 1));
      end else if (n >= 10 && n <= 17) begin
        e = F_QRD | F_EXEC | qk(4'(n - 10));
        if (n > 10) e = e | F_PWR | pa(4'(n - 11));
      end else if (n == 18) begin
        e = F_PWR | pa(4'd7);
      end
      check($sformatf("exec_cyc%0d", n), 64'(inst), 64'(e));
      if (n == 18) check("exec_done_early", 64'(done), 64'd0);
      @(negedge clk);
    end
    check("exec_done", 64'(done), 64'd1);
    check("exec_done_inst", 64'(inst), 64'd0);
    check("exec_done_busy", 64'(busy), 64'd0);

    // Reset in the middle of an EXEC command.
    issue(2'd2, 4'd0, 4'd7);
    repeat (12) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_inst", 64'(inst), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_data_ready", 64'(data_ready), 64'd0);
    @(posedge clk);
    #1;
    check("midrst_inst_held", 64'(inst), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst_busy_after", 64'(busy), 64'd0);
`ifdef INST_SEQ_PERF_EN
    check("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    sbq.delete();
    mon_en = 1'b1;
    run_cmd(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
